apb_param_slave: RTL and testbench
==================================

APB_PARAM_SLAVE -- requirements
Module: apb_param_slave

Interface
REQ-001 Parameter ADDR_W, default 10: PADDR width in bits; byte address.
REQ-002 Parameter DATA_W, default 32: PWDATA/PRDATA width; SHALL be 8, 16, 32 or 64.
REQ-003 Parameter DEPTH, default 128: number of DATA_W-bit words in the register file.
REQ-004 Parameter WAIT_CYCLES, default 1, range 0..15: wait states inserted per transfer.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 psel_i  in  1  APB select.
REQ-008 penable_i  in  1  APB enable (ACCESS phase).
REQ-009 paddr_i  in  ADDR_W  byte address.
REQ-010 pwrite_i  in  1  1 = write, 0 = read.
REQ-011 pwdata_i  in  DATA_W  write data.
REQ-012 pstrb_i  in  DATA_W/8  byte-lane write strobes.
REQ-013 prdata_o  out  DATA_W  read data.
REQ-014 pready_o  out  1  transfer complete.
REQ-015 pslverr_o  out  1  transfer error.

Function
REQ-016 Word index idx = paddr_i[ADDR_W-1:log2(DATA_W/8)]; low address bits SHALL be ignored; address is out of range when idx >= DEPTH.
REQ-017 FSM states IDLE, ACCESS; IDLE -> ACCESS on an edge sampling psel_i=1, penable_i=0, loading wait counter with WAIT_CYCLES.
REQ-018 In ACCESS: psel_i=0 -> IDLE (abort, no write, no error); else counter nonzero -> decrement; else transfer completes -> IDLE.
REQ-019 pready_o = (state==ACCESS) and (counter==0); ACCESS therefore lasts exactly WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 gives zero-wait transfer.
REQ-020 Completion edge = rising clk with psel_i, penable_i, pready_o all 1; writes commit only on this edge.
REQ-021 Write: each byte lane b with pstrb_i[b]=1 SHALL be updated from pwdata_i; lanes with strobe 0 unchanged; pstrb_i=0 is a legal no-op write.
REQ-022 Read: prdata_o = mem[idx] while pready_o=1 and pwrite_i=0; otherwise prdata_o = 0.
REQ-023 Read-after-write to same index in the next transfer SHALL return the updated data.
REQ-024 paddr_i, pwrite_i, pwdata_i, pstrb_i sampled at completion; master holds them stable per APB.
REQ-025 psel_i=1 with penable_i=1 while IDLE (protocol violation) SHALL be ignored; FSM stays IDLE.
REQ-026 Back-to-back transfers: new SETUP sampled on the edge after completion; no extra idle cycle required.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, counter 0, all memory words 0, pready_o=0, pslverr_o=0, prdata_o=0.
REQ-028 Reset asserted mid-transfer SHALL abort it with no memory update; after release the first valid SETUP starts a new transfer.

Configuration
REQ-029 Macro APB_PARAM_SLAVE_PSLVERR_EN defined: pslverr_o = pready_o and address out of range; out-of-range writes discarded, reads return 0.
REQ-030 Macro undefined: pslverr_o tied 0; out-of-range writes discarded silently, reads return 0; timing identical.

Verification
REQ-031 Defaults, reset, write 0xDEADBEEF to paddr 0x0A, pstrb 0xF, then read 0x0A -> pready_o high 2nd ACCESS cycle each, prdata_o=0xDEADBEEF.
REQ-032 Write 0x11223344 to 0x10, then 0xAABBCCDD with pstrb 0x5, read 0x10 -> prdata_o=0x11BB33DD.
REQ-033 WAIT_CYCLES=0 and WAIT_CYCLES=3, one read each -> pready_o in 1st and 4th ACCESS cycle respectively, exactly one cycle wide.
REQ-034 With macro, write then read paddr 0x200 (idx 128) -> pslverr_o=1 with pready_o, prdata_o=0, no word modified; without macro pslverr_o=0.
REQ-035 Drop psel_i in 1st ACCESS cycle of write to 0x04, then read 0x04 -> prdata_o=0x00000000.
REQ-036 Assert reset_n=0 during wait state of write to 0x08 after prior write 0x5 there -> pready_o=0 at once, read 0x08 afterwards returns 0.

Source files
------------

// File: rtl/apb_param_slave.sv
// apb_param_slave: APB register-file slave with a DEPTH x DATA_W word array,
// byte-lane write strobes and a fixed WAIT_CYCLES wait-state count.
// Optional build macro APB_PARAM_SLAVE_PSLVERR_EN: drive pslverr_o for
// out-of-range word indices (otherwise pslverr_o is tied low).
module apb_param_slave #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic                pwrite_i,
    input  logic [DATA_W-1:0]   pwdata_i,
    input  logic [DATA_W/8-1:0] pstrb_i,
    output logic [DATA_W-1:0]   prdata_o,
    output logic                pready_o,
    output logic                pslverr_o
);

    localparam int          NB      = DATA_W / 8;
    localparam int          LSB     = $clog2(NB);
    localparam int          IDX_W   = ADDR_W - LSB;
    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [IDX_W-1:0]    w_idx;
    logic [MEM_AW-1:0]   w_widx;
    logic                w_in_range;
    logic                w_commit;
    logic                w_wr_en;

    // Word index drops the byte-offset bits; anything past DEPTH is out of range
    assign w_idx      = paddr_i[ADDR_W-1:LSB];
    assign w_widx     = MEM_AW'(w_idx);
    assign w_in_range = (32'(w_idx) < DEPTH_U);

    generate
        if (LSB > 0) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^paddr_i[LSB-1:0];
        end
    endgenerate

    // State and wait counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: SETUP opens ACCESS, then count down wait states; dropping
    // psel aborts. psel+penable seen in IDLE is a protocol error and ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (psel_i && !penable_i) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = WAIT_LD;
                end
            end
            S_ACCESS: begin
                if (!psel_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign pready_o = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_commit = psel_i && penable_i && pready_o;
    assign w_wr_en  = w_commit && pwrite_i && w_in_range;

    // Register file: cleared by reset, byte-lane writes on the completion edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (pstrb_i[b]) begin
                    r_mem[w_widx][8*b +: 8] <= pwdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is only presented while the read is completing
    assign prdata_o = (pready_o && !pwrite_i && w_in_range) ? r_mem[w_widx] : '0;

`ifdef APB_PARAM_SLAVE_PSLVERR_EN
    assign pslverr_o = pready_o && !w_in_range;
`else
    assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_param_slave.sv
// Bench for apb_param_slave: directed scenarios plus randomized transfers
// compared against a word-array model of the register file.
module tb_apb_param_slave;

    localparam int WAIT = 1;

    logic        clk;
    logic        reset_n;
    logic        psel_i;
    logic        penable_i;
    logic [9:0]  paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic [31:0] prdata_o,  prdata_w0,  prdata_w3;
    logic        pready_o,  pready_w0,  pready_w3;
    logic        pslverr_o, pslverr_w0, pslverr_w3;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model [128];

    apb_param_slave u_dut (
        .clk(clk), .reset_n(reset_n), .psel_i(psel_i), .penable_i(penable_i),
        .paddr_i(paddr_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o)
    );

    apb_param_slave #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .psel_i(psel_i), .penable_i(penable_i),
        .paddr_i(paddr_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .prdata_o(prdata_w0), .pready_o(pready_w0), .pslverr_o(pslverr_w0)
    );

    apb_param_slave #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset_n(reset_n), .psel_i(psel_i), .penable_i(penable_i),
        .paddr_i(paddr_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .prdata_o(prdata_w3), .pready_o(pready_w3), .pslverr_o(pslverr_w3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_clear();
        for (int i = 0; i < 128; i++) model[i] = 32'h0;
    endfunction

    function automatic void mdl_write(input logic [9:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
        int idx = int'(a) / 4;
        if (idx < 128)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] mdl_read(input logic [9:0] a);
        int idx = int'(a) / 4;
        return (idx < 128) ? model[idx] : 32'h0;
    endfunction

    function automatic logic mdl_err(input logic [9:0] a);
`ifdef APB_PARAM_SLAVE_PSLVERR_EN
        return (int'(a) / 4) >= 128;
`else
        return 1'b0;
`endif
    endfunction

    // One APB transfer; called at posedge+1, returns at posedge+1.
    task automatic xfer(input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit b2b, input string tag);
        int cyc = 0;
        bit seen = 0;
        logic [31:0] rd = 32'h0;
        logic err = 1'b0;
        psel_i = 1'b1; penable_i = 1'b0;
        pwrite_i = wr; paddr_i = a; pwdata_i = d; pstrb_i = s;
        @(posedge clk); #1;
        penable_i = 1'b1;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (pready_o) begin
                seen = 1; rd = prdata_o; err = pslverr_o;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_ready_cycle"}, 64'(cyc), 64'(WAIT + 1));
        chk({tag, "_pslverr"}, 64'(err), 64'(mdl_err(a)));
        if (!wr) chk({tag, "_rdata"}, 64'(rd), 64'(mdl_read(a)));
        else mdl_write(a, d, s);
        @(posedge clk); #1;
        chk({tag, "_ready_drop"}, 64'(pready_o), 64'd0);
        if (!b2b) begin
            psel_i = 1'b0; penable_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [4:0] p0, p1, p3;
        reset_n = 1'b0; psel_i = 0; penable_i = 0; paddr_i = '0;
        pwrite_i = 0; pwdata_i = '0; pstrb_i = '0;
        mdl_clear();
        #12;
        chk("rst_pready", 64'(pready_o), 64'd0);
        chk("rst_pslverr", 64'(pslverr_o), 64'd0);
        chk("rst_prdata", 64'(prdata_o), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Wait-state timing across WAIT_CYCLES = 0, 1, 3 on one held read
        psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 10'h00A;
        @(posedge clk); #1;
        penable_i = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            p0[k] = pready_w0; p1[k] = pready_o; p3[k] = pready_w3;
            @(posedge clk); #1;
        end
        psel_i = 0; penable_i = 0;
        chk("wait0_ready", 64'(p0), 64'b00001);
        chk("wait1_ready", 64'(p1), 64'b00010);
        chk("wait3_ready", 64'(p3), 64'b01000);
        @(posedge clk); #1;

        // Basic write/read and byte strobes
        xfer(1, 10'h00A, 32'hDEADBEEF, 4'hF, 0, "wr_0a");
        xfer(0, 10'h00A, 32'h0, 4'h0, 0, "rd_0a");
        chk("rd_0a_value", 64'(mdl_read(10'h00A)), 64'hDEADBEEF);
        xfer(1, 10'h010, 32'h11223344, 4'hF, 1, "wr_10");
        xfer(1, 10'h010, 32'hAABBCCDD, 4'h5, 1, "wr_10_strb");
        xfer(0, 10'h010, 32'h0, 4'h0, 0, "rd_10");
        chk("rd_10_value", 64'(mdl_read(10'h010)), 64'h11BB33DD);
        xfer(1, 10'h014, 32'h55555555, 4'h0, 0, "wr_nostrb");
        xfer(0, 10'h014, 32'h0, 4'h0, 0, "rd_nostrb");

        // Out-of-range word index 128 must not alias word 0
        xfer(1, 10'h200, 32'h12345678, 4'hF, 0, "wr_oor");
        xfer(0, 10'h200, 32'h0, 4'h0, 0, "rd_oor");
        xfer(0, 10'h000, 32'h0, 4'h0, 0, "rd_word0");

        // Abort: psel dropped in first ACCESS cycle
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 10'h004;
        pwdata_i = 32'hFFFFFFFF; pstrb_i = 4'hF;
        @(posedge clk); #1;
        psel_i = 0; penable_i = 0;
        @(negedge clk);
        chk("abort_ready", 64'(pready_o), 64'd0);
        @(posedge clk); #1;
        xfer(0, 10'h004, 32'h0, 4'h0, 0, "rd_abort");

        // Protocol violation in IDLE is ignored
        psel_i = 1; penable_i = 1; pwrite_i = 0; paddr_i = 10'h00A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_viol_ready", 64'(pready_o), 64'd0);
        end
        @(posedge clk); #1;
        psel_i = 0; penable_i = 0;
        @(posedge clk); #1;

        // Reset during a wait state
        xfer(1, 10'h008, 32'h00000005, 4'hF, 0, "wr_08");
        xfer(0, 10'h008, 32'h0, 4'h0, 0, "rd_08_pre");
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 10'h008;
        pwdata_i = 32'hCAFEF00D; pstrb_i = 4'hF;
        @(posedge clk); #1;
        penable_i = 1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(pready_o), 64'd0);
        chk("midrst_prdata", 64'(prdata_o), 64'd0);
        @(posedge clk); #1;
        psel_i = 0; penable_i = 0;
        mdl_clear();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 10'h008, 32'h0, 4'h0, 0, "rd_08_post");
        chk("rd_08_post_value", 64'(mdl_read(10'h008)), 64'd0);

        // Randomized mix against the model
        for (int n = 0; n < 60; n++) begin
            int idx;
            logic [9:0] a;
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(128, 255))
                                              : int'($urandom_range(0, 15));
            a = 10'(idx * 4 + int'($urandom_range(0, 3)));
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
